// File: rtl/alu32_pkg.sv
// Shared ALU datapath definitions: divider FSM states, widths and a two's-complement helper.
package alu32_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_ITERS = 32;
    localparam int unsigned DIV_CNT_W = 6;

    typedef logic [DIV_WIDTH-1:0] div_word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    function automatic div_word_t neg32(input div_word_t v);
        return (~v) + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/cla_adder32.sv
// 32-bit carry-lookahead adder/subtractor: 4-bit lookahead groups, group carries chained by G/P.
module cla_adder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] sum,
    output logic        C32,
    output logic        of
);

    logic [31:0] bx;
    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] cin_bit;
    logic [7:0]  grp_g;
    logic [7:0]  grp_p;
    logic [7:0]  grp_c;

    assign bx = b ^ {32{sub}};
    assign g  = a & bx;
    assign p  = a ^ bx;

    for (genvar gi = 0; gi < 8; gi++) begin : g_grp
        localparam int unsigned B = gi * 4;

        assign grp_p[gi] = &p[B+3:B];
        assign grp_g[gi] = g[B+3]
                         | (p[B+3] & g[B+2])
                         | (p[B+3] & p[B+2] & g[B+1])
                         | (p[B+3] & p[B+2] & p[B+1] & g[B]);

        assign cin_bit[B]   = grp_c[gi];
        assign cin_bit[B+1] = g[B] | (p[B] & grp_c[gi]);
        assign cin_bit[B+2] = g[B+1]
                            | (p[B+1] & g[B])
                            | (p[B+1] & p[B] & grp_c[gi]);
        assign cin_bit[B+3] = g[B+2]
                            | (p[B+2] & g[B+1])
                            | (p[B+2] & p[B+1] & g[B])
                            | (p[B+2] & p[B+1] & p[B] & grp_c[gi]);
    end

    // Group carries are built from group G/P only, so no bit carry feeds back into its own vector.
    always_comb begin
        logic c;
        grp_c = '0;
        c     = sub;
        for (int unsigned i = 0; i < 8; i++) begin
            grp_c[i] = c;
            c        = grp_g[i] | (grp_p[i] & c);
        end
        C32 = c;
    end

    assign sum = p ^ cin_bit;
    assign of  = cin_bit[31] ^ C32;

endmodule

// File: rtl/div32_seq.sv
// div32_seq: multi-cycle 32-bit restoring divider, one quotient bit per cycle, start/busy/done handshake.
// Signed (truncating) division is compiled in only when DIV32_SIGNED_EN is defined.
module div32_seq
    import alu32_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 sgn,
    input  logic [DIV_WIDTH-1:0] dividend,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic                 busy,
    output logic                 done,
    output logic [DIV_WIDTH-1:0] quotient,
    output logic [DIV_WIDTH-1:0] remainder,
    output logic                 dbz,
    output logic                 of
);

    div_state_t           state_q;
    div_state_t           state_d;
    logic [DIV_CNT_W-1:0] cnt_q;
    div_word_t            rem_q;
    div_word_t            quo_q;
    div_word_t            dsr_q;
    div_word_t            rem_sh;
    div_word_t            trial;
    div_word_t            op_a;
    div_word_t            op_b;
    logic                 trial_c32;
    logic                 adder_of_unused;
    logic                 take;
    logic                 last_iter;

    assign rem_sh    = {rem_q[DIV_WIDTH-2:0], quo_q[DIV_WIDTH-1]};
    assign last_iter = (cnt_q == DIV_CNT_W'(DIV_ITERS - 1));

    cla_adder32 u_trial_sub (
        .a   (rem_sh),
        .b   (dsr_q),
        .sub (1'b1),
        .sum (trial),
        .C32 (trial_c32),
        .of  (adder_of_unused)
    );

    // A 1 shifted out of R means the 33-bit partial remainder already exceeds any divisor.
    assign take = trial_c32 | rem_q[DIV_WIDTH-1];

`ifdef DIV32_SIGNED_EN
    logic sa;
    logic sb;
    logic ovf;
    logic neg_q_q;
    logic neg_r_q;
    logic of_pend_q;

    assign sa   = sgn & dividend[DIV_WIDTH-1];
    assign sb   = sgn & divisor[DIV_WIDTH-1];
    assign op_a = sa ? neg32(dividend) : dividend;
    assign op_b = sb ? neg32(divisor) : divisor;
    assign ovf  = sgn && (dividend == {1'b1, {(DIV_WIDTH-1){1'b0}}}) && (divisor == '1);
`else
    logic unused_sgn;

    assign unused_sgn = sgn;
    assign op_a       = dividend;
    assign op_b       = divisor;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                busy    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dsr_q     <= '0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= dividend;
                            dbz       <= 1'b1;
                        end else begin
                            quo_q <= op_a;
                            dsr_q <= op_b;
                            rem_q <= '0;
                            cnt_q <= '0;
                            dbz   <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    rem_q <= take ? trial : rem_sh;
                    quo_q <= {quo_q[DIV_WIDTH-2:0], take};
                    cnt_q <= cnt_q + 1'b1;
                end
                FIX: begin
`ifdef DIV32_SIGNED_EN
                    quotient  <= neg_q_q ? neg32(quo_q) : quo_q;
                    remainder <= neg_r_q ? neg32(rem_q) : rem_q;
`else
                    quotient  <= quo_q;
                    remainder <= rem_q;
`endif
                end
                default: ;
            endcase
        end
    end

`ifdef DIV32_SIGNED_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            of_pend_q <= 1'b0;
            of        <= 1'b0;
        end else begin
            if (state_q == IDLE && start) begin
                neg_q_q   <= sa ^ sb;
                neg_r_q   <= sa;
                of_pend_q <= ovf;
                of        <= 1'b0;
            end else if (state_q == FIX) begin
                of <= of_pend_q;
            end
        end
    end
`else
    assign of = 1'b0;
`endif

endmodule

// File: tb/tb_div32_seq.sv
// Directed self-checking bench for div32_seq: latency, results, flags, handshake and reset abort.
module tb_div32_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        sgn;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        dbz;
    logic        of;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div32_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sgn       (sgn),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz),
        .of        (of)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called one step after an edge with the DUT idle; returns in the done cycle (or at the cycle bound).
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input int repulse_at,
                           output logic [31:0] q, output logic [31:0] r,
                           output logic z, output logic o,
                           output int lat, output int busy_low);
        dividend = a;
        divisor  = b;
        sgn      = s;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = ~a;
        divisor  = ~b;
        lat      = 1;
        busy_low = 0;
        while (!done && lat < 100) begin
            if (!busy) busy_low++;
            if (lat == repulse_at) begin
                start    = 1'b1;
                dividend = 32'd55;
                divisor  = 32'd5;
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end
        if (!busy) busy_low++;
        q = quotient;
        r = remainder;
        z = dbz;
        o = of;
    endtask

    task automatic div_case(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic s, input logic [31:0] eq, input logic [31:0] er,
                            input logic ez, input logic eo, input int elat, input int repulse_at);
        logic [31:0] q, r;
        logic        z, o;
        int          lat, bl;
        run_div(a, b, s, repulse_at, q, r, z, o, lat, bl);
        check({tag, ".lat"}, 32'(lat), 32'(elat));
        check({tag, ".done"}, {31'd0, done}, 32'd1);
        check({tag, ".q"}, q, eq);
        check({tag, ".r"}, r, er);
        check({tag, ".dbz"}, {31'd0, z}, {31'd0, ez});
        check({tag, ".of"}, {31'd0, o}, {31'd0, eo});
        check({tag, ".busylow"}, 32'(bl), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q, r;
        logic        z, o;
        int          lat, bl, seen;

        rst_n    = 1'b0;
        start    = 1'b0;
        sgn      = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.busy", {31'd0, busy}, 32'd0);
        check("rst.done", {31'd0, done}, 32'd0);
        check("rst.q", quotient, 32'h0);
        check("rst.r", remainder, 32'h0);
        check("rst.dbz", {31'd0, dbz}, 32'd0);
        check("rst.of", {31'd0, of}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        div_case("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0, 34, 0);
        div_case("umax_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 34, 0);
        div_case("umax_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd1, 32'd0, 1'b0, 1'b0, 34, 0);
        div_case("ubig", 32'hFFFF_FFFE, 32'h8000_0001, 1'b0, 32'd1, 32'h7FFF_FFFD, 1'b0, 1'b0, 34, 0);
        div_case("usmall", 32'd5, 32'd10, 1'b0, 32'd0, 32'd5, 1'b0, 1'b0, 34, 0);
        div_case("ubeef", 32'hDEAD_BEEF, 32'h10, 1'b0, 32'h0DEA_DBEE, 32'hF, 1'b0, 1'b0, 34, 0);
        div_case("dbz", 32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0, 1, 0);
        div_case("u_after_dbz", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0, 34, 0);

`ifdef DIV32_SIGNED_EN
        div_case("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 34, 0);
        div_case("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0, 34, 0);
        div_case("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 34, 0);
        div_case("s_off", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0, 1'b0, 34, 0);
`else
        div_case("sgn_ign", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0, 1'b0, 34, 0);
        div_case("sgn_ign_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0, 1'b0, 34, 0);
`endif

        // start re-pulsed mid-run with other operands must not disturb the result
        div_case("repulse", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0, 34, 10);

        // start in the done cycle is ignored; start in the following cycle is accepted
        run_div(32'd50, 32'd6, 1'b0, 0, q, r, z, o, lat, bl);
        check("pre_done.q", q, 32'd8);
        check("pre_done.r", r, 32'd2);
        dividend = 32'd77;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("done_start.busy", {31'd0, busy}, 32'd0);
        div_case("after_done", 32'd81, 32'd9, 1'b0, 32'd9, 32'd0, 1'b0, 1'b0, 34, 0);

        // reset during RUN aborts without a done pulse
        dividend = 32'd1000;
        divisor  = 32'd7;
        sgn      = 1'b0;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("midrun.busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort.busy", {31'd0, busy}, 32'd0);
        check("abort.done", {31'd0, done}, 32'd0);
        check("abort.q", quotient, 32'h0);
        check("abort.r", remainder, 32'h0);
        check("abort.dbz", {31'd0, dbz}, 32'd0);
        check("abort.of", {31'd0, of}, 32'd0);
        rst_n = 1'b1;
        seen  = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("abort.nodone", 32'(seen), 32'd0);
        div_case("after_rst", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 1'b0, 34, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div32_seq.md
# div32_seq

Multi-cycle 32-bit restoring divider, the inverse-direction companion to the 32-bit carry-lookahead adder/subtractor in the ALU datapath. It performs repeated shift-and-subtract using the existing adder in subtract mode, one quotient bit per cycle, behind a start/busy/done handshake. The ALU top level issues DIV/REM operations to it and stalls on `busy`.

## Interface
- Parameters: none. Width is fixed at 32 to match `cla_adder32`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: request a division; sampled only in IDLE.
- `sgn` in 1: signed division request; honoured only when `DIV32_SIGNED_EN` is defined.
- `dividend` in 32: numerator; sampled together with `start`.
- `divisor` in 32: denominator; sampled together with `start`.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse; results are valid in that cycle and held until the next accepted `start`.
- `quotient` out 32: quotient result.
- `remainder` out 32: remainder result.
- `dbz` out 1: divide-by-zero flag, valid with `done`.
- `of` out 1: signed overflow flag (-2^31 / -1), valid with `done`.

## Operation
- States: IDLE, RUN, FIX, DONE.
- Reset values: state IDLE; `busy`, `done`, `dbz` and `of` are 0; `quotient` and `remainder` are 0x00000000.
- IDLE with `start`=1 and `divisor`≠0:
  - Latch operands; with signed mode active, latch their magnitudes and both sign bits.
  - Clear the partial remainder R. Set the iteration count to 0. Go to RUN.
- IDLE with `start`=1 and `divisor`=0:
  - Go to DONE with `quotient`=0xFFFFFFFF, `remainder`=`dividend`, `dbz`=1.
- RUN, each cycle:
  - Shift {R, Q} left by 1.
  - Trial D = R − divisor through `cla_adder32` (sub=1).
  - If C32=1 (no borrow), R←D and Q[0]←1; otherwise R is unchanged and Q[0]←0.
  - Exactly 32 iterations, then go to FIX.
- FIX: apply sign correction (signed mode only).
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Register the outputs and go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `of`=1 only for signed 0x80000000 / 0xFFFFFFFF. The result is then `quotient`=0x80000000 and `remainder`=0, which falls out of the algorithm naturally.
- `start` while `busy`=1 is ignored; the operands are not re-sampled.
- `start` in the DONE cycle is ignored. The earliest new `start` is accepted in the cycle after `done`.
- Reset asserted mid-operation aborts the division:
  - All state returns to reset values at the next edge.
  - No `done` pulse is produced.

## Timing
- `start` sampled at edge k:
  - RUN occupies edges k+1..k+32.
  - FIX is at edge k+33.
  - `done`=1 in the cycle after edge k+33, i.e. 34 cycles after the `start` cycle.
- Latency is fixed regardless of operand values or sign mode.
- Divide-by-zero: `done` is asserted 1 cycle after the `start` cycle.
- `busy` is high for every cycle between acceptance and `done`, inclusive of the `done` cycle.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- Critical path: one 32-bit CLA subtraction plus the R mux per cycle.

## Configuration
- Macro: `DIV32_SIGNED_EN`.
- Defined:
  - `sgn`=1 selects two's-complement division with truncation toward zero.
  - The FIX stage performs the negations, and `of` is live.
- Undefined:
  - `sgn` is ignored and all division is unsigned.
  - FIX passes results through unchanged, keeping the same 34-cycle latency.
  - `of` is tied to 0, and no negation logic is synthesised.

## Structure
- `alu32_pkg` holds:
  - the state enum `div_state_t` (IDLE, RUN, FIX, DONE);
  - `DIV_WIDTH` = 32;
  - `DIV_ITERS` = 32;
  - iteration counter width = 6.
- Sub-module: one instance of the existing `cla_adder32` with `sub` tied to 1, used for the trial subtraction. Its `C32` output serves as the no-borrow indicator; its `of` output is unused.
- The remaining logic is a single module: FSM, counter, the R/Q shift registers, and FIX negation.

## Test plan
- Unsigned 100 / 7:
  - `done` is asserted exactly 34 cycles after `start`.
  - `quotient`=14, `remainder`=2, `dbz`=0.
- 0xFFFFFFFF / 1 unsigned: `quotient`=0xFFFFFFFF, `remainder`=0.
- 0x12345678 / 0 → `done` after 1 cycle, `dbz`=1, `quotient`=0xFFFFFFFF, `remainder`=0x12345678.
- Signed, with `DIV32_SIGNED_EN`:
  - −7 / 2 → `quotient`=0xFFFFFFFD (−3), `remainder`=0xFFFFFFFF (−1).
  - 0x80000000 / 0xFFFFFFFF → `quotient`=0x80000000, `remainder`=0, `of`=1.
- Handshake:
  - `start` re-pulsed at cycle 10 of an operation with new operands → ignored; the result matches the original operands.
  - `start` in the cycle after `done` → accepted.
- `rst_n`=0 at RUN iteration 15 → next cycle IDLE, all outputs 0, no `done`. A fresh 9/3 then yields `quotient`=3, `remainder`=0.
